// File: rtl/stack_reverser.sv
// Reverses a word stream through an external LIFO stack: each accepted word is
// pushed, then the whole frame is popped back out on in_last or when the stack fills.
module stack_reverser #(
  parameter int ADDR_BITS = 3,
  parameter int WORD_BITS = 8
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic [WORD_BITS-1:0] in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 out_ready,
  output logic [WORD_BITS-1:0] out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 in_ready,
  output logic [1:0]           out_stack_cmd,
  output logic [WORD_BITS-1:0] out_stack_data,
  input  logic [WORD_BITS-1:0] in_stack_top,
  input  logic                 in_stack_ready
);

  localparam int            CW    = ADDR_BITS + 1;
  localparam logic [CW-1:0] DEPTH = CW'(1 << ADDR_BITS);
  localparam logic [CW-1:0] ONE   = CW'(1);

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_PUSH = 2'b01;
  localparam logic [1:0] CMD_POP  = 2'b10;

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_ISSUE_PUSH,
    ST_PUSH_WAIT,
    ST_EMIT,
    ST_ISSUE_POP,
    ST_POP_WAIT
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_count;
  logic [WORD_BITS-1:0] r_data;
  logic                 r_last_flag;
  logic [1:0]           r_cmd;
  logic                 r_valid;
  logic                 r_out_last;
  logic                 r_ready;

  logic          w_accept;
  logic [CW-1:0] w_count_inc;
  logic [CW-1:0] w_count_dec;

  assign w_accept    = in_valid & r_ready;
  assign w_count_inc = r_count + ONE;
  assign w_count_dec = r_count - ONE;

  // Outputs are registered alongside the state they belong to, so the stack
  // command never sees in_stack_ready through a combinational path.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_state     <= ST_COLLECT;
      r_count     <= '0;
      r_data      <= '0;
      r_last_flag <= 1'b0;
      r_cmd       <= CMD_NOP;
      r_valid     <= 1'b0;
      r_out_last  <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_cmd      <= CMD_NOP;
      r_valid    <= 1'b0;
      r_out_last <= 1'b0;
      r_ready    <= 1'b0;
      case (r_state)
        ST_COLLECT: begin
          if (w_accept) begin
            r_data      <= in_data;
            r_last_flag <= in_last;
            r_count     <= w_count_inc;
            r_cmd       <= CMD_PUSH;
            r_state     <= ST_ISSUE_PUSH;
          end else begin
            r_ready <= (r_count < DEPTH);
          end
        end
        ST_ISSUE_PUSH: r_state <= ST_PUSH_WAIT;
        ST_PUSH_WAIT: begin
          if (in_stack_ready) begin
            if (r_last_flag || (r_count == DEPTH)) begin
              r_valid    <= 1'b1;
              r_out_last <= (r_count == ONE);
              r_state    <= ST_EMIT;
            end else begin
              r_ready <= (r_count < DEPTH);
              r_state <= ST_COLLECT;
            end
          end
        end
        ST_EMIT: begin
          if (in_ready) begin
            r_count <= w_count_dec;
            r_cmd   <= CMD_POP;
            r_state <= ST_ISSUE_POP;
          end else begin
            r_valid    <= 1'b1;
            r_out_last <= (r_count == ONE);
          end
        end
        ST_ISSUE_POP: r_state <= ST_POP_WAIT;
        ST_POP_WAIT: begin
          if (in_stack_ready) begin
            if (r_count == '0) begin
              r_ready <= 1'b1;
              r_state <= ST_COLLECT;
            end else begin
              r_valid    <= 1'b1;
              r_out_last <= (r_count == ONE);
              r_state    <= ST_EMIT;
            end
          end
        end
        default: r_state <= ST_COLLECT;
      endcase
    end
  end

  assign out_ready      = r_ready;
  assign out_valid      = r_valid;
  assign out_last       = r_out_last;
  assign out_stack_cmd  = r_cmd;
  assign out_stack_data = r_data;
  // The stack is idle while emitting, so its top word is stable downstream data.
  assign out_data       = r_valid ? in_stack_top : '0;

endmodule

// File: doc/stack_reverser.md
Name: stack_reverser

Overview:
- Initiator for the LIFO stack command interface.
- Accepts a stream of words over valid/ready and pushes each word onto an external stack instance.
- On the last word, or when the stack is full, pops all stored words and emits them downstream in reverse order, also over valid/ready.
- Sits between a stream producer and consumer; the stack is instantiated beside it and shares clock and reset.

Parameters:
- ADDR_BITS, 3, stack address width; capacity DEPTH = 2**ADDR_BITS words; must match the stack instance.
- WORD_BITS, 8, data word width; must match the stack instance.

Ports:
- in_clk  input  1  clock, rising edge.
- in_rst  input  1  reset; asynchronous, active-high.
- in_data  input  WORD_BITS  upstream word.
- in_valid  input  1  upstream word valid.
- in_last  input  1  upstream word is the last of its frame.
- out_ready  output  1  block accepts an upstream word this cycle.
- out_data  output  WORD_BITS  downstream word.
- out_valid  output  1  downstream word valid.
- out_last  output  1  downstream word is the last of its frame.
- in_ready  input  1  downstream accepts a word.
- out_stack_cmd  output  2  stack command: 00 nop, 01 push, 10 pop.
- out_stack_data  output  WORD_BITS  word to push.
- in_stack_top  input  WORD_BITS  stack word at the stack pointer.
- in_stack_ready  input  1  stack idle and ready; it depends combinationally on the command being nop.

Behaviour:
- Reset:
  - Async assert forces state Collect, count 0, data register 0.
  - During reset: out_stack_cmd=00, out_valid=0, out_last=0, out_ready=0.
  - out_ready rises on the first cycle after deassertion.
  - The stack must receive the same reset, held for at least one in_clk edge; its synchronous reset then clears its pointer, keeping count consistent.
  - Reset mid-operation abandons the frame; no partial output follows.
- out_stack_cmd is decoded from the state register only. It must never depend combinationally on in_stack_ready, because that path is a combinational loop.
- Stack protocol, as issued by this block:
  - A command is driven for exactly one cycle, then nop.
  - No new command until in_stack_ready is sampled 1.
  - out_stack_data is held stable from the push cycle until ready returns.
- count: ADDR_BITS+1 bits, range 0..DEPTH.
- States:
  - Collect: out_ready = (count < DEPTH). On in_valid & out_ready, latch in_data into the data register, latch in_last into last_flag, count+1, go to IssuePush.
  - IssuePush: out_stack_cmd=01, out_ready=0. Go to PushWait.
  - PushWait: cmd=00. When in_stack_ready=1: if last_flag or count==DEPTH go to Emit, else go to Collect.
  - Emit: out_valid=1, out_data=in_stack_top, out_last=(count==1). On in_ready, count-1 and go to IssuePop. Otherwise hold; out_data stays stable because the stack is idle.
  - IssuePop: out_stack_cmd=10. Go to PopWait.
  - PopWait: cmd=00. When in_stack_ready=1: if count==0 go to Collect, else go to Emit.
- Timing:
  - Accept at edge T gives cmd=01 in T+1 and ready sampled in T+4.
  - out_ready is high again from T+5, so at most one word is accepted per 5 cycles.
  - Drain handshake at T gives the next out_valid at T+4.
- Boundaries:
  - Full: the DEPTH-th word enters drain even if in_last=0; out_last marks the final emitted word.
  - Single-word frame: pushed, then emitted once with out_last=1.
  - in_valid during any non-Collect state is ignored (out_ready=0); the producer holds its word.
  - in_ready=0 stalls Emit indefinitely with no stack activity.
  - The stack pointer wraps modulo DEPTH; with count ≤ DEPTH no slot is overwritten.

Test Plan:
- Reset → out_ready=1, out_valid=0, out_stack_cmd=00. Push 0x11,0x22,0x33 (0x33 with in_last) → output 0x33,0x22,0x11, out_last only on 0x11, then out_ready=1.
- Frame of 8 words 0x01..0x08 with in_last never set → out_ready=0 after the 8th; output 0x08..0x01 with out_last on 0x01.
- Single word 0xA5 with in_last → one output 0xA5, out_last=1, count returns to 0.
- Drain 3 words while holding in_ready=0 for 10 cycles → out_valid held and out_data constant; no stack command issued during the stall.
- in_valid held high continuously → exactly one out_stack_cmd=01 pulse per accepted word; pushes spaced 5 cycles apart; each pop's cmd=10 pulse is one cycle wide.
- Assert in_rst after 2 of 4 words were accepted → all outputs return to reset values immediately. A new frame 0x7E,0x7F (last) then outputs 0x7F,0x7E only.
